// File: rtl/modmul_pkg.sv
// Shared constants for the modular-multiplication datapath: default modulus,
// Barrett constant, the Barrett constant helper and this reducer's latency.
package modmul_pkg;

  localparam int              DEF_LOGQ   = 38;
  localparam logic [37:0]     DEF_Q      = 38'd137438953473;   // 2^37 + 1
  localparam logic [39:0]     DEF_MU     = 40'd549755813884;   // floor(2^76 / Q)
  localparam int              MODRED_LAT = 6;

  // floor(2^(2*logq) / q); valid while 2*logq fits the 128-bit numerator
  function automatic logic [63:0] barrett_mu(input int logq, input logic [63:0] q);
    logic [127:0] num;
    num = 128'd1 << (2 * logq);
    return 64'(num / {64'd0, q});
  endfunction

endpackage

// File: rtl/modred_cond_sub.sv
// Registered conditional subtract: y <= (x >= QV) ? x - QV : x, truncated to OW.
// Loads only when en is high, otherwise holds; clears on synchronous reset.
module modred_cond_sub #(
  parameter int           W  = 40,
  parameter int           OW = 40,
  parameter logic [W-1:0] QV = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [W-1:0]  x,
  output logic [OW-1:0] y
);

  logic [W-1:0]  diff_s;
  logic [OW-1:0] next_s;

  // select the reduced value and fit it to the output width
  always_comb begin
    diff_s = x;
    if (x >= QV) begin
      diff_s = x - QV;
    end else begin
      diff_s = x;
    end
    next_s = OW'(diff_s);
  end

  // output register with enable and synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= {OW{1'b0}};
    end else if (en) begin
      y <= next_s;
    end else begin
      y <= y;
    end
  end

endmodule

// File: rtl/modred_barrett_pipe.sv
// Six-stage Barrett reducer: R = C mod Q for C < Q^2, one input per cycle,
// no backpressure. A valid shift register runs alongside the data.
module modred_barrett_pipe
  import modmul_pkg::*;
#(
  parameter int                LOGQ = DEF_LOGQ,
  parameter logic [LOGQ-1:0]   Q    = DEF_Q,
  parameter logic [LOGQ+1:0]   MU   = DEF_MU
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2*LOGQ-1:0]    C,
  output logic                 out_valid,
  output logic [LOGQ-1:0]      R
);

  localparam int              LAT = MODRED_LAT;
  localparam int              RW  = LOGQ + 2;
  localparam int              PW  = 2 * LOGQ + 3;
  localparam logic [RW-1:0]   QW  = {2'b00, Q};

  // A mismatched MU silently breaks the error bound of the quotient estimate.
  if (LOGQ <= 62) begin : g_mu_check
    if (MU != (LOGQ+2)'(barrett_mu(LOGQ, 64'(Q)))) begin : g_mu_bad
      $error("modred_barrett_pipe: MU does not equal floor(2^(2*LOGQ)/Q)");
    end
  end

  logic [LAT-1:0]     v_r;
  logic [2*LOGQ-1:0]  c1_r;
  logic [RW-1:0]      c2_r;
  logic [RW-1:0]      c3_r;
  logic [RW-1:0]      t3_r;
  logic [RW-1:0]      t4_r;
  logic [RW-1:0]      r0_r;
  logic [RW-1:0]      r1_s;
  logic [LOGQ:0]      t1_s;
  logic [PW-1:0]      t2_s;
  logic [RW-1:0]      t3_s;
  logic [RW-1:0]      t4_s;
  logic [RW-1:0]      r0_s;

  // quotient estimate, its product with Q, and the low-bits remainder
  always_comb begin
    t1_s = c1_r[2*LOGQ-1:LOGQ-1];
    t2_s = {{(LOGQ+2){1'b0}}, t1_s} * {{(LOGQ+1){1'b0}}, MU};
    t3_s = RW'(t2_s >> (LOGQ+1));
    t4_s = t3_r * QW;                 // only the low RW bits of t3*Q matter
    r0_s = c3_r - t4_r;
  end

  // valid chain: clears on reset so in-flight items are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= {LAT{1'b0}};
    end else begin
      v_r <= {v_r[LAT-2:0], in_valid};
    end
  end

  // data stages S1-S4: capture every cycle, no reset needed.
  // Only the upper part of t1*MU is kept; its low bits never reach the result.
  always_ff @(posedge clk) begin
    c1_r <= C;
    c2_r <= c1_r[RW-1:0];
    t3_r <= t3_s;
    c3_r <= c2_r;
    t4_r <= t4_s;
    r0_r <= r0_s;
  end

  // S5: first correction, r0 in [0,3Q) -> r1 in [0,2Q)
  modred_cond_sub #(.W(RW), .OW(RW), .QV(QW)) u_sub1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .x     (r0_r),
    .y     (r1_s)
  );

  // S6: second correction into the output register, loads only for valid items
  modred_cond_sub #(.W(RW), .OW(LOGQ), .QV(QW)) u_sub2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_r[LAT-2]),
    .x     (r1_s),
    .y     (R)
  );

  assign out_valid = v_r[LAT-1];

endmodule
